rom_port_arbiter: RTL

Two-port arbiter and sequencer in front of the program ROM. It shares the single combinational read port between the CPU instruction-fetch path and a debug/loader read path. It translates byte addresses in the text segment into in-range word accesses, registers each read result with one-cycle latency, and flags illegal addresses. It sits between the fetch stage, the debug interface and the program memory.

---
 rtl/rom_port_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one combinational ROM read port between instruction fetch and debug.
// Granted byte addresses are range-checked; each port's response appears one cycle after its grant.
module rom_port_arbiter #(
  parameter int                  MEMORY_DEPTH = 64,
  parameter int                  DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req_i,
  input  logic [DATA_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_gnt_o,
  output logic                  fetch_rvalid_o,
  output logic [DATA_WIDTH-1:0] fetch_rdata_o,
  output logic                  fetch_err_o,
  input  logic                  dbg_req_i,
  input  logic [DATA_WIDTH-1:0] dbg_addr_i,
  output logic                  dbg_gnt_o,
  output logic                  dbg_rvalid_o,
  output logic [DATA_WIDTH-1:0] dbg_rdata_o,
  output logic                  dbg_err_o,
  output logic [DATA_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [7:0]            err_count_o
);

  localparam logic [DATA_WIDTH-1:0] LP_SPAN = DATA_WIDTH'(MEMORY_DEPTH) << 2;

  // Handshake: a requester holds req with a stable address; the request is consumed at the
  // rising edge where gnt is high, and rvalid/rdata/err are presented for exactly the next cycle.
  logic                  r_prio;
  logic                  r_fetch_rvalid;
  logic [DATA_WIDTH-1:0] r_fetch_rdata;
  logic                  r_fetch_err;
  logic                  r_dbg_rvalid;
  logic [DATA_WIDTH-1:0] r_dbg_rdata;
  logic                  r_dbg_err;
  logic [7:0]            r_err_count;

  logic                  w_fetch_gnt;
  logic                  w_dbg_gnt;
  logic [DATA_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_offset;
  logic                  w_legal;
  logic [DATA_WIDTH-1:0] w_rdata;

  always_comb begin
    w_fetch_gnt = !reset && fetch_req_i && (!dbg_req_i || !r_prio);
    w_dbg_gnt   = !reset && dbg_req_i && (!fetch_req_i || r_prio);
    if (w_fetch_gnt)
      w_addr = fetch_addr_i;
    else if (w_dbg_gnt)
      w_addr = dbg_addr_i;
    else
      w_addr = BASE_ADDR;
    // Compare the unshifted offset so an address far above the ROM cannot alias back into range.
    w_offset = w_addr - BASE_ADDR;
    w_legal  = (w_addr[1:0] == 2'b00) && (w_addr >= BASE_ADDR) && (w_offset < LP_SPAN);
    w_rdata  = w_legal ? rom_data_i : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio         <= 1'b0;
      r_fetch_rvalid <= 1'b0;
      r_fetch_rdata  <= '0;
      r_fetch_err    <= 1'b0;
      r_dbg_rvalid   <= 1'b0;
      r_dbg_rdata    <= '0;
      r_dbg_err      <= 1'b0;
      r_err_count    <= 8'd0;
    end else begin
      r_fetch_rvalid <= w_fetch_gnt;
      r_dbg_rvalid   <= w_dbg_gnt;
      if (w_fetch_gnt) begin
        r_prio        <= 1'b1;
        r_fetch_rdata <= w_rdata;
        r_fetch_err   <= !w_legal;
      end
      if (w_dbg_gnt) begin
        r_prio      <= 1'b0;
        r_dbg_rdata <= w_rdata;
        r_dbg_err   <= !w_legal;
      end
      if ((w_fetch_gnt || w_dbg_gnt) && !w_legal && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
    end
  end

  assign fetch_gnt_o    = w_fetch_gnt;
  assign dbg_gnt_o      = w_dbg_gnt;
  assign rom_addr_o     = w_addr;
  assign fetch_rvalid_o = r_fetch_rvalid;
  assign fetch_rdata_o  = r_fetch_rdata;
  assign fetch_err_o    = r_fetch_err;
  assign dbg_rvalid_o   = r_dbg_rvalid;
  assign dbg_rdata_o    = r_dbg_rdata;
  assign dbg_err_o      = r_dbg_err;
  assign err_count_o    = r_err_count;

endmodule
